// File: rtl/ddr_arb_pkg.sv
// Shared encodings for the DDR2 bus-master arbiter: FSM state codes and bus-owner codes.
package ddr_arb_pkg;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCmd  = 2'd1;
  localparam logic [1:0] StWait = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  localparam logic OWN_DISP = 1'b0;
  localparam logic OWN_GPU  = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way display/GPU picker with a registered round-robin pointer.
// Optional urgent-display override is enabled by defining HDMI_ARB_URGENT_EN.
module rr_arb2
  import ddr_arb_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req_disp_i,
  input  logic req_gpu_i,
  input  logic urgent_i,
  input  logic update_i,
  output logic any_o,
  output logic pick_o
);

  // Pointer names the requester that did not win last; reset favours the display.
  logic ptr_q, ptr_d;

  always_comb begin
    any_o = req_disp_i | req_gpu_i;
    if (req_disp_i && req_gpu_i) begin
      pick_o = ptr_q;
    end else begin
      pick_o = req_gpu_i ? OWN_GPU : OWN_DISP;
    end
`ifdef HDMI_ARB_URGENT_EN
    if (req_disp_i && urgent_i) begin
      pick_o = OWN_DISP;
    end
`endif
    ptr_d = ptr_q;
    if (update_i && any_o) begin
      ptr_d = ~pick_o;
    end
  end

`ifndef HDMI_ARB_URGENT_EN
  logic unused_urgent;
  assign unused_urgent = urgent_i;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= OWN_DISP;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/ddr_master_arb.sv
// Display/GPU arbiter and command sequencer for the single IPIF master port into DDR2.
// Define HDMI_ARB_URGENT_EN to let an urgent display request override round-robin.
module ddr_master_arb
  import ddr_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned LEN_W   = 12,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic              Bus2IP_Clk,
  input  logic              Bus2IP_Resetn,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  input  logic [LEN_W-1:0]  disp_len,
  input  logic              disp_urgent,
  output logic              disp_gnt,
  output logic              disp_done,
  input  logic              gpu_req,
  input  logic              gpu_rnw,
  input  logic [ADDR_W-1:0] gpu_addr,
  input  logic [LEN_W-1:0]  gpu_len,
  output logic              gpu_gnt,
  output logic              gpu_done,
  output logic              xfer_err,
  output logic              owner,
  output logic              IP2Bus_MstRd_Req,
  output logic              IP2Bus_MstWr_Req,
  output logic [ADDR_W-1:0] IP2Bus_Mst_Addr,
  output logic [LEN_W-1:0]  IP2Bus_Mst_Length,
  input  logic              Bus2IP_Mst_CmdAck,
  input  logic              Bus2IP_Mst_Cmplt,
  input  logic              Bus2IP_Mst_Error
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;
  logic              rnw_q, rnw_d;
  logic              err_q, err_d;
  logic              disp_gnt_q, disp_gnt_d;
  logic              gpu_gnt_q, gpu_gnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic              any_req;
  logic              pick;
  logic [LEN_W-1:0]  pick_len;

  rr_arb2 u_rr_arb2 (
    .clk_i      (Bus2IP_Clk),
    .rst_ni     (Bus2IP_Resetn),
    .req_disp_i (disp_req),
    .req_gpu_i  (gpu_req),
    .urgent_i   (disp_urgent),
    .update_i   (state_q == StIdle),
    .any_o      (any_req),
    .pick_o     (pick)
  );

  assign pick_len = (pick == OWN_GPU) ? gpu_len : disp_len;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rnw_d      = rnw_q;
    err_d      = err_q;
    addr_d     = addr_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    disp_gnt_d = 1'b0;
    gpu_gnt_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          disp_gnt_d = (pick == OWN_DISP);
          gpu_gnt_d  = (pick == OWN_GPU);
          owner_d    = pick;
          addr_d     = (pick == OWN_GPU) ? gpu_addr : disp_addr;
          len_d      = pick_len;
          rnw_d      = (pick == OWN_GPU) ? gpu_rnw : 1'b1;
          cnt_d      = '0;
          err_d      = 1'b0;
          // Zero-length commands never touch the bus.
          if (pick_len == '0) begin
            state_d = StDone;
            err_d   = 1'b1;
          end else begin
            state_d = StCmd;
          end
        end
      end
      StCmd: begin
        cnt_d = cnt_q + CntW'(1);
        if (Bus2IP_Mst_CmdAck && Bus2IP_Mst_Cmplt) begin
          state_d = StDone;
          err_d   = Bus2IP_Mst_Error;
        end else if (cnt_q == CntMax) begin
          state_d = StDone;
          err_d   = 1'b1;
        end else if (Bus2IP_Mst_CmdAck) begin
          state_d = StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q + CntW'(1);
        if (Bus2IP_Mst_Cmplt) begin
          state_d = StDone;
          err_d   = Bus2IP_Mst_Error;
        end else if (cnt_q == CntMax) begin
          state_d = StDone;
          err_d   = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn) begin
      state_q    <= StIdle;
      owner_q    <= OWN_DISP;
      rnw_q      <= 1'b0;
      err_q      <= 1'b0;
      disp_gnt_q <= 1'b0;
      gpu_gnt_q  <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rnw_q      <= rnw_d;
      err_q      <= err_d;
      disp_gnt_q <= disp_gnt_d;
      gpu_gnt_q  <= gpu_gnt_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
    end
  end

  assign disp_gnt          = disp_gnt_q;
  assign gpu_gnt           = gpu_gnt_q;
  assign disp_done         = (state_q == StDone) && (owner_q == OWN_DISP);
  assign gpu_done          = (state_q == StDone) && (owner_q == OWN_GPU);
  assign xfer_err          = (state_q == StDone) && err_q;
  assign owner             = owner_q;
  assign IP2Bus_MstRd_Req  = (state_q == StCmd) && rnw_q;
  assign IP2Bus_MstWr_Req  = (state_q == StCmd) && !rnw_q;
  assign IP2Bus_Mst_Addr   = addr_q;
  assign IP2Bus_Mst_Length = len_q;

endmodule

// File: tb/tb_ddr_master_arb.sv
// Scoreboard bench for ddr_master_arb: stimulus queues expected grants/dones, a monitor checks them.
module tb_ddr_master_arb;

  localparam int AW = 32;
  localparam int LW = 12;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          disp_req, disp_urgent, disp_gnt, disp_done;
  logic [AW-1:0] disp_addr;
  logic [LW-1:0] disp_len;
  logic          gpu_req, gpu_rnw, gpu_gnt, gpu_done;
  logic [AW-1:0] gpu_addr;
  logic [LW-1:0] gpu_len;
  logic          xfer_err, owner, rd_req, wr_req;
  logic [AW-1:0] mst_addr;
  logic [LW-1:0] mst_len;
  logic          cmd_ack, cmplt, mst_err;

  ddr_master_arb #(.ADDR_W(AW), .LEN_W(LW), .TIMEOUT(TO)) dut (
    .Bus2IP_Clk        (clk),
    .Bus2IP_Resetn     (rst_n),
    .disp_req          (disp_req),
    .disp_addr         (disp_addr),
    .disp_len          (disp_len),
    .disp_urgent       (disp_urgent),
    .disp_gnt          (disp_gnt),
    .disp_done         (disp_done),
    .gpu_req           (gpu_req),
    .gpu_rnw           (gpu_rnw),
    .gpu_addr          (gpu_addr),
    .gpu_len           (gpu_len),
    .gpu_gnt           (gpu_gnt),
    .gpu_done          (gpu_done),
    .xfer_err          (xfer_err),
    .owner             (owner),
    .IP2Bus_MstRd_Req  (rd_req),
    .IP2Bus_MstWr_Req  (wr_req),
    .IP2Bus_Mst_Addr   (mst_addr),
    .IP2Bus_Mst_Length (mst_len),
    .Bus2IP_Mst_CmdAck (cmd_ack),
    .Bus2IP_Mst_Cmplt  (cmplt),
    .Bus2IP_Mst_Error  (mst_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          own;
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
  } gnt_t;

  typedef struct packed {
    logic own;
    logic err;
    int   lat;
  } done_t;

  gnt_t  gq[$];
  done_t dq[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  // Bus responder configuration: delays counted from the grant cycle.
  int ack_dly   = 0;
  int cmplt_dly = 0;
  bit cmplt_en  = 1'b0;
  bit err_en    = 1'b0;

  int mon_cyc = 0;
  int gnt_cyc = 0;
  int rk      = 100000;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_gnt(input logic own, input logic rnw, input logic [AW-1:0] a,
                            input logic [LW-1:0] l);
    gnt_t g;
    g.own  = own;
    g.rd   = (l != '0) && rnw;
    g.wr   = (l != '0) && !rnw;
    g.addr = a;
    g.len  = l;
    gq.push_back(g);
  endtask

  task automatic expect_done(input logic own, input logic err, input int lat);
    done_t d;
    d.own = own;
    d.err = err;
    d.lat = lat;
    dq.push_back(d);
  endtask

  // Monitor: pops and compares on every grant or done pulse.
  initial begin : monitor
    gnt_t  eg;
    done_t ed;
    forever begin
      @(negedge clk);
      mon_cyc++;
      if (disp_gnt || gpu_gnt) begin
        gnt_cyc = mon_cyc;
        if (gq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_gnt: got disp=%0b gpu=%0b expected no grant", disp_gnt, gpu_gnt);
        end else begin
          eg = gq.pop_front();
          check("gnt_who", {62'd0, disp_gnt, gpu_gnt}, eg.own ? 64'd1 : 64'd2);
          check("gnt_owner", {63'd0, owner}, {63'd0, eg.own});
          check("gnt_rd_req", {63'd0, rd_req}, {63'd0, eg.rd});
          check("gnt_wr_req", {63'd0, wr_req}, {63'd0, eg.wr});
          check("gnt_addr", {32'd0, mst_addr}, {32'd0, eg.addr});
          check("gnt_len", {52'd0, mst_len}, {52'd0, eg.len});
        end
      end
      if (disp_done || gpu_done) begin
        if (dq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done: got disp=%0b gpu=%0b expected no done", disp_done, gpu_done);
        end else begin
          ed = dq.pop_front();
          check("done_who", {62'd0, disp_done, gpu_done}, ed.own ? 64'd1 : 64'd2);
          check("done_err", {63'd0, xfer_err}, {63'd0, ed.err});
          if (ed.lat >= 0) check("done_latency", 64'(mon_cyc - gnt_cyc), 64'(ed.lat));
        end
      end
    end
  end

  // Bus slave model: acks and completes at fixed offsets from the latest grant.
  initial begin : responder
    cmd_ack = 1'b0;
    cmplt   = 1'b0;
    mst_err = 1'b0;
    forever begin
      @(negedge clk);
      if (disp_gnt || gpu_gnt) rk = 0;
      cmd_ack = (rk == ack_dly) && (rd_req || wr_req);
      cmplt   = cmplt_en && (rk == cmplt_dly);
      mst_err = err_en && cmplt;
      if (rk < 100000) rk++;
    end
  end

  task automatic wait_gnts(input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < 200 && seen < n; i++) begin
      @(negedge clk);
      if (disp_gnt || gpu_gnt) seen++;
    end
    if (seen < n) begin
      n_cmp++;
      n_bad++;
      $display("FAIL gnt_timeout: got %0d grants expected %0d", seen, n);
    end
  endtask

  task automatic req_one(input logic who, input logic rnw, input logic [AW-1:0] a,
                         input logic [LW-1:0] l);
    @(negedge clk);
    if (who) begin
      gpu_req = 1'b1; gpu_rnw = rnw; gpu_addr = a; gpu_len = l;
    end else begin
      disp_req = 1'b1; disp_addr = a; disp_len = l;
    end
    wait_gnts(1);
    disp_req = 1'b0;
    gpu_req  = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && (gq.size() != 0 || dq.size() != 0); i++) @(negedge clk);
    repeat (12) @(negedge clk);
    check("queues_drained", 64'(gq.size() + dq.size()), 64'd0);
  endtask

  initial begin : stimulus
    disp_req = 1'b0; disp_urgent = 1'b0; disp_addr = '0; disp_len = '0;
    gpu_req = 1'b0; gpu_rnw = 1'b1; gpu_addr = '0; gpu_len = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("reset_outs", {56'd0, disp_gnt, disp_done, gpu_gnt, gpu_done, xfer_err, owner,
                         rd_req, wr_req}, 64'd0);
    check("reset_addr_len", {20'd0, mst_addr, mst_len}, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Display read: ack at +2, complete at +10, done one cycle after completion.
    ack_dly = 2; cmplt_dly = 10; cmplt_en = 1'b1; err_en = 1'b0;
    expect_gnt(1'b0, 1'b1, 32'h1000_0000, 12'd256);
    expect_done(1'b0, 1'b0, 11);
    req_one(1'b0, 1'b1, 32'h1000_0000, 12'd256);
    drain();

    // Minimum latency: ack and complete in the first command cycle.
    ack_dly = 0; cmplt_dly = 0;
    expect_gnt(1'b1, 1'b1, 32'h2000_0040, 12'd64);
    expect_done(1'b1, 1'b0, 1);
    req_one(1'b1, 1'b1, 32'h2000_0040, 12'd64);
    drain();

    // Both requesting continuously: alternate starting with display; GPU writes.
    for (int i = 0; i < 2; i++) begin
      expect_gnt(1'b0, 1'b1, 32'h0000_1000, 12'd128);
      expect_done(1'b0, 1'b0, 1);
      expect_gnt(1'b1, 1'b0, 32'h3000_0000, 12'd32);
      expect_done(1'b1, 1'b0, 1);
    end
    @(negedge clk);
    disp_req = 1'b1; disp_addr = 32'h0000_1000; disp_len = 12'd128;
    gpu_req = 1'b1; gpu_rnw = 1'b0; gpu_addr = 32'h3000_0000; gpu_len = 12'd32;
    wait_gnts(4);
    disp_req = 1'b0; gpu_req = 1'b0;
    drain();

    // GPU won last; urgent display request.
    expect_gnt(1'b0, 1'b1, 32'h0000_2000, 12'd16);
    expect_done(1'b0, 1'b0, 1);
`ifdef HDMI_ARB_URGENT_EN
    expect_gnt(1'b0, 1'b1, 32'h0000_2000, 12'd16);
    expect_done(1'b0, 1'b0, 1);
`else
    expect_gnt(1'b1, 1'b1, 32'h3000_1000, 12'd8);
    expect_done(1'b1, 1'b0, 1);
`endif
    @(negedge clk);
    disp_req = 1'b1; disp_urgent = 1'b1; disp_addr = 32'h0000_2000; disp_len = 12'd16;
    gpu_req = 1'b1; gpu_rnw = 1'b1; gpu_addr = 32'h3000_1000; gpu_len = 12'd8;
    wait_gnts(2);
    disp_req = 1'b0; gpu_req = 1'b0; disp_urgent = 1'b0;
    drain();

    // Zero length: grant and error done together, bus untouched.
    cmplt_en = 1'b0;
    expect_gnt(1'b1, 1'b0, 32'h4000_0000, 12'd0);
    expect_done(1'b1, 1'b1, 0);
    req_one(1'b1, 1'b0, 32'h4000_0000, 12'd0);
    drain();

    // Bus error reported with completion.
    ack_dly = 1; cmplt_dly = 3; cmplt_en = 1'b1; err_en = 1'b1;
    expect_gnt(1'b1, 1'b1, 32'h5000_0100, 12'd512);
    expect_done(1'b1, 1'b1, 4);
    req_one(1'b1, 1'b1, 32'h5000_0100, 12'd512);
    drain();
    err_en = 1'b0;

    // Timeout: completion withheld past TIMEOUT, then a late one arrives in idle.
    ack_dly = 1; cmplt_dly = 20; cmplt_en = 1'b1;
    expect_gnt(1'b1, 1'b0, 32'h6000_0000, 12'd4);
    expect_done(1'b1, 1'b1, TO);
    req_one(1'b1, 1'b0, 32'h6000_0000, 12'd4);
    drain();

    // Reset in the middle of a display transfer: no done, pointer back to display.
    ack_dly = 1; cmplt_en = 1'b0;
    expect_gnt(1'b0, 1'b1, 32'h7000_0000, 12'd100);
    req_one(1'b0, 1'b1, 32'h7000_0000, 12'd100);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_outs", {56'd0, disp_gnt, disp_done, gpu_gnt, gpu_done, xfer_err, owner,
                            rd_req, wr_req}, 64'd0);
    check("midreset_addr_len", {20'd0, mst_addr, mst_len}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ack_dly = 0; cmplt_dly = 0; cmplt_en = 1'b1;
    expect_gnt(1'b0, 1'b1, 32'h7000_0000, 12'd100);
    expect_done(1'b0, 1'b0, 1);
    expect_gnt(1'b1, 1'b1, 32'h3000_2000, 12'd24);
    expect_done(1'b1, 1'b0, 1);
    @(negedge clk);
    disp_req = 1'b1; disp_addr = 32'h7000_0000; disp_len = 12'd100;
    gpu_req = 1'b1; gpu_rnw = 1'b1; gpu_addr = 32'h3000_2000; gpu_len = 12'd24;
    wait_gnts(2);
    disp_req = 1'b0; gpu_req = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
